// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one cached SDRAM controller port between two requesters: the Hazard3
// instruction-fetch path on port 0 and the load/store path on port 1.
// Arbitration is round-robin. The arbiter converts each requester's level
// req/ack handshake into the single-cycle rd_en/wr_en pulse the controller
// expects, keeps one access outstanding at a time, and aborts an access that
// never completes.
//
// Sequence per access: IDLE (grant) -> ISSUE (enable pulse) -> WAIT (until
// m_busy is low, or the watchdog expires) -> DONE (ack pulse). This gives an
// ack three cycles after a request that is seen in IDLE.
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   p0_* / p1_*           requester ports: req/we/addr/wdata/mask in,
//                         ack (one-cycle pulse) and rdata out
//   m_rd_en, m_wr_en      one-cycle command pulses to the controller
//   m_addr/m_wdata/m_mask command fields, stable from ISSUE through DONE
//   m_rdata, m_busy       controller read data and busy
//   err, err_port         sticky watchdog flag, port of the last abort
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int          ADDR_W   = 32,
   parameter int          TIMEOUT  = 4096,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [31:0]       p0_wdata,
   input  logic [3:0]        p0_mask,
   output logic              p0_ack,
   output logic [31:0]       p0_rdata,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [31:0]       p1_wdata,
   input  logic [3:0]        p1_mask,
   output logic              p1_ack,
   output logic [31:0]       p1_rdata,

   output logic              m_rd_en,
   output logic              m_wr_en,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_wdata,
   output logic [3:0]        m_mask,
   input  logic [31:0]       m_rdata,
   input  logic              m_busy,

   output logic              err,
   output logic              err_port
);

   localparam int             CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Registered state
   state_t            r_state;
   logic              r_rr_last;   // port granted most recently
   logic              r_grant;     // port owning the current access
   logic              r_we;        // current access is a write
   logic [CNT_W-1:0]  r_cnt;       // busy cycles seen in WAIT
   logic              r_m_rd_en;
   logic              r_m_wr_en;
   logic [ADDR_W-1:0] r_m_addr;
   logic [31:0]       r_m_wdata;
   logic [3:0]        r_m_mask;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [31:0]       r_p0_rdata;
   logic [31:0]       r_p1_rdata;
   logic              r_err;
   logic              r_err_port;

   // Next-state values
   state_t            w_state_nxt;
   logic              w_rr_last_nxt;
   logic              w_grant_nxt;
   logic              w_we_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_m_rd_en_nxt;
   logic              w_m_wr_en_nxt;
   logic [ADDR_W-1:0] w_m_addr_nxt;
   logic [31:0]       w_m_wdata_nxt;
   logic [3:0]        w_m_mask_nxt;
   logic              w_p0_ack_nxt;
   logic              w_p1_ack_nxt;
   logic [31:0]       w_p0_rdata_nxt;
   logic [31:0]       w_p1_rdata_nxt;
   logic              w_err_nxt;
   logic              w_err_port_nxt;

   logic              w_gnt;
   logic [CNT_W-1:0]  w_cnt_inc;

   // With both ports requesting, the port that did not go last wins. With a
   // single requester, p1_req alone selects port 1 and otherwise port 0.
   assign w_gnt     = (p0_req && p1_req) ? ~r_rr_last : p1_req;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_rr_last_nxt  = r_rr_last;
      w_grant_nxt    = r_grant;
      w_we_nxt       = r_we;
      w_cnt_nxt      = r_cnt;
      w_m_rd_en_nxt  = 1'b0;
      w_m_wr_en_nxt  = 1'b0;
      w_m_addr_nxt   = r_m_addr;
      w_m_wdata_nxt  = r_m_wdata;
      w_m_mask_nxt   = r_m_mask;
      w_p0_ack_nxt   = 1'b0;
      w_p1_ack_nxt   = 1'b0;
      w_p0_rdata_nxt = r_p0_rdata;
      w_p1_rdata_nxt = r_p1_rdata;
      w_err_nxt      = r_err;
      w_err_port_nxt = r_err_port;

      unique case (r_state)
         ST_IDLE: begin
            // A controller still busy (e.g. after a reset mid-access) blocks
            // any new grant until it goes idle.
            if (!m_busy && (p0_req || p1_req)) begin
               w_grant_nxt   = w_gnt;
               w_rr_last_nxt = w_gnt;
               w_we_nxt      = w_gnt ? p1_we    : p0_we;
               w_m_addr_nxt  = w_gnt ? p1_addr  : p0_addr;
               w_m_wdata_nxt = w_gnt ? p1_wdata : p0_wdata;
               w_m_mask_nxt  = w_gnt ? p1_mask  : p0_mask;
               w_m_rd_en_nxt = w_gnt ? ~p1_we   : ~p0_we;
               w_m_wr_en_nxt = w_gnt ? p1_we    : p0_we;
               w_state_nxt   = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT;
         end

         ST_WAIT: begin
            if (!m_busy) begin
               // Completion; write accesses leave rdata untouched.
               if (!r_we) begin
                  if (r_grant) w_p1_rdata_nxt = m_rdata;
                  else         w_p0_rdata_nxt = m_rdata;
               end
               w_p0_ack_nxt = ~r_grant;
               w_p1_ack_nxt = r_grant;
               w_state_nxt  = ST_DONE;
            end else if (w_cnt_inc == TIMEOUT_C) begin
               // Watchdog abort after TIMEOUT busy cycles in WAIT.
               if (r_grant) w_p1_rdata_nxt = ERR_DATA;
               else         w_p0_rdata_nxt = ERR_DATA;
               w_err_nxt      = 1'b1;
               w_err_port_nxt = r_grant;
               w_p0_ack_nxt   = ~r_grant;
               w_p1_ack_nxt   = r_grant;
               w_state_nxt    = ST_DONE;
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values from before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_rr_last  <= 1'b1;     // port 0 wins the first contested grant
         r_grant    <= 1'b0;
         r_we       <= 1'b0;
         r_cnt      <= '0;
         r_m_rd_en  <= 1'b0;
         r_m_wr_en  <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
         r_m_mask   <= '0;
         r_p0_ack   <= 1'b0;
         r_p1_ack   <= 1'b0;
         r_p0_rdata <= '0;
         r_p1_rdata <= '0;
         r_err      <= 1'b0;
         r_err_port <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rr_last  <= w_rr_last_nxt;
         r_grant    <= w_grant_nxt;
         r_we       <= w_we_nxt;
         r_cnt      <= w_cnt_nxt;
         r_m_rd_en  <= w_m_rd_en_nxt;
         r_m_wr_en  <= w_m_wr_en_nxt;
         r_m_addr   <= w_m_addr_nxt;
         r_m_wdata  <= w_m_wdata_nxt;
         r_m_mask   <= w_m_mask_nxt;
         r_p0_ack   <= w_p0_ack_nxt;
         r_p1_ack   <= w_p1_ack_nxt;
         r_p0_rdata <= w_p0_rdata_nxt;
         r_p1_rdata <= w_p1_rdata_nxt;
         r_err      <= w_err_nxt;
         r_err_port <= w_err_port_nxt;
      end
   end

   assign m_rd_en  = r_m_rd_en;
   assign m_wr_en  = r_m_wr_en;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign m_mask   = r_m_mask;
   assign p0_ack   = r_p0_ack;
   assign p1_ack   = r_p1_ack;
   assign p0_rdata = r_p0_rdata;
   assign p1_rdata = r_p1_rdata;
   assign err      = r_err;
   assign err_port = r_err_port;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with TIMEOUT=16. Inputs change and
// outputs are sampled on the falling clock edge; "cycle n" below is the clock
// period whose rising edge ends it, cycle 0 being the one in which a request
// is first presented.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              p0_req, p0_we, p0_ack;
   logic [ADDR_W-1:0] p0_addr;
   logic [31:0]       p0_wdata, p0_rdata;
   logic [3:0]        p0_mask;
   logic              p1_req, p1_we, p1_ack;
   logic [ADDR_W-1:0] p1_addr;
   logic [31:0]       p1_wdata, p1_rdata;
   logic [3:0]        p1_mask;
   logic              m_rd_en, m_wr_en, m_busy;
   logic [ADDR_W-1:0] m_addr;
   logic [31:0]       m_wdata, m_rdata;
   logic [3:0]        m_mask;
   logic              err, err_port;

   int n_checks = 0;
   int n_fail   = 0;
   int waited;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W   (ADDR_W),
      .TIMEOUT  (TIMEOUT),
      .ERR_DATA (32'hDEAD_BEEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .p0_req   (p0_req),
      .p0_we    (p0_we),
      .p0_addr  (p0_addr),
      .p0_wdata (p0_wdata),
      .p0_mask  (p0_mask),
      .p0_ack   (p0_ack),
      .p0_rdata (p0_rdata),
      .p1_req   (p1_req),
      .p1_we    (p1_we),
      .p1_addr  (p1_addr),
      .p1_wdata (p1_wdata),
      .p1_mask  (p1_mask),
      .p1_ack   (p1_ack),
      .p1_rdata (p1_rdata),
      .m_rd_en  (m_rd_en),
      .m_wr_en  (m_wr_en),
      .m_addr   (m_addr),
      .m_wdata  (m_wdata),
      .m_mask   (m_mask),
      .m_rdata  (m_rdata),
      .m_busy   (m_busy),
      .err      (err),
      .err_port (err_port)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Waits up to 'budget' cycles for the given port's ack.
   task automatic wait_ack(input logic port, input int budget, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (((port ? p1_ack : p0_ack) == 1'b0) && (n < budget));
      check("ack_seen", 32'(port ? p1_ack : p0_ack), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst = 1'b1;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_mask = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_mask = '0;
      m_rdata = '0; m_busy = 1'b0;

      // ---------------- reset state ----------------
      tick(); tick();
      check("rst_rd_en",   32'(m_rd_en),  32'd0);
      check("rst_wr_en",   32'(m_wr_en),  32'd0);
      check("rst_p0_ack",  32'(p0_ack),   32'd0);
      check("rst_p1_ack",  32'(p1_ack),   32'd0);
      check("rst_err",     32'(err),      32'd0);
      check("rst_err_port",32'(err_port), 32'd0);
      check("rst_m_addr",  m_addr,        32'd0);
      check("rst_m_wdata", m_wdata,       32'd0);
      check("rst_m_mask",  32'(m_mask),   32'd0);
      check("rst_p0_rdata",p0_rdata,      32'd0);
      check("rst_p1_rdata",p1_rdata,      32'd0);

      // ---------------- port 0 read hit ----------------
      rst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h100; m_rdata = 32'h1234_5678;
      for (int c = 1; c <= 4; c++) begin
         tick();
         check("rd_rd_en",  32'(m_rd_en), 32'(c == 1));
         check("rd_wr_en",  32'(m_wr_en), 32'd0);
         check("rd_p0_ack", 32'(p0_ack),  32'(c == 3));
         check("rd_p1_ack", 32'(p1_ack),  32'd0);
         if (c == 1) check("rd_m_addr", m_addr, 32'h100);
         if (c == 3) begin
            check("rd_p0_rdata", p0_rdata, 32'h1234_5678);
            p0_req = 1'b0;
         end
      end

      // ---------------- round robin, both ports held ----------------
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h20;
      m_rdata = 32'hA5A5_0000;
      for (int c = 1; c <= 23; c++) begin
         int ph;
         logic exp_port;
         tick();
         ph       = c % 4;
         exp_port = ((c / 4) % 2) == 1;
         check("rr_rd_en",  32'(m_rd_en), 32'(ph == 1));
         check("rr_wr_en",  32'(m_wr_en), 32'd0);
         check("rr_p0_ack", 32'(p0_ack),  32'(ph == 3 && !exp_port));
         check("rr_p1_ack", 32'(p1_ack),  32'(ph == 3 && exp_port));
         if (ph == 1) check("rr_m_addr", m_addr, exp_port ? 32'h20 : 32'h10);
         if (c == 23) begin
            p0_req = 1'b0;
            p1_req = 1'b0;
         end
      end

      // ---------------- port 1 write with 10 busy cycles ----------------
      tick();
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h2000;
      p1_wdata = 32'hCAFE_F00D; p1_mask = 4'b0011;
      for (int c = 1; c <= 14; c++) begin
         tick();
         check("wr_wr_en",  32'(m_wr_en), 32'(c == 1));
         check("wr_rd_en",  32'(m_rd_en), 32'd0);
         check("wr_p1_ack", 32'(p1_ack),  32'(c == 13));
         check("wr_p0_ack", 32'(p0_ack),  32'd0);
         if (c <= 13) begin
            check("wr_m_addr",  m_addr,       32'h2000);
            check("wr_m_wdata", m_wdata,      32'hCAFE_F00D);
            check("wr_m_mask",  32'(m_mask),  32'h3);
         end
         if (c == 1)  m_busy = 1'b1;
         if (c == 12) m_busy = 1'b0;
         if (c == 13) begin
            check("wr_p1_rdata_kept", p1_rdata, 32'hA5A5_0000);
            check("wr_err", 32'(err), 32'd0);
            p1_req = 1'b0;
         end
      end

      // ---------------- watchdog abort on port 1 ----------------
      tick();
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h400;
      for (int c = 1; c <= 19; c++) begin
         tick();
         check("to_p1_ack", 32'(p1_ack), 32'(c == 18));
         check("to_err",    32'(err),    32'(c >= 18));
         if (c == 1) m_busy = 1'b1;
         if (c == 18) begin
            check("to_p1_rdata",  p1_rdata,      32'hDEAD_BEEF);
            check("to_err_port",  32'(err_port), 32'd1);
            p1_req = 1'b0;
            m_busy = 1'b0;
         end
      end
      // A later good access leaves err set.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h500; m_rdata = 32'h0BAD_F00D;
      wait_ack(1'b0, 20, waited);
      check("post_to_latency",  32'(waited),   32'd3);
      check("post_to_p0_rdata", p0_rdata,      32'h0BAD_F00D);
      check("post_to_err",      32'(err),      32'd1);
      check("post_to_err_port", 32'(err_port), 32'd1);
      p0_req = 1'b0;

      // ---------------- reset during WAIT with controller busy ----------------
      tick();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h700; m_rdata = 32'h7777_7777;
      for (int c = 1; c <= 9; c++) begin
         tick();
         if (c == 1) begin
            check("mr_first_rd_en", 32'(m_rd_en), 32'd1);
            m_busy = 1'b1;
         end
         if (c == 3) rst = 1'b1;
         if (c == 4 || c == 5) begin
            check("mr_p0_ack",   32'(p0_ack),   32'd0);
            check("mr_p1_ack",   32'(p1_ack),   32'd0);
            check("mr_err",      32'(err),      32'd0);
            check("mr_err_port", 32'(err_port), 32'd0);
            check("mr_rd_en",    32'(m_rd_en),  32'd0);
            check("mr_p0_rdata", p0_rdata,      32'd0);
         end
         if (c == 5) rst = 1'b0;
         if (c >= 6 && c <= 8) begin
            check("mr_busy_rd_en", 32'(m_rd_en), 32'd0);
            check("mr_busy_wr_en", 32'(m_wr_en), 32'd0);
         end
         if (c == 8) m_busy = 1'b0;
         if (c == 9) begin
            check("mr_grant_rd_en", 32'(m_rd_en), 32'd1);
            check("mr_grant_addr",  m_addr,       32'h700);
         end
      end
      wait_ack(1'b0, 10, waited);
      check("mr_latency",  32'(waited), 32'd2);
      check("mr_rdata",    p0_rdata,    32'h7777_7777);
      check("mr_err_after",32'(err),    32'd0);
      p0_req = 1'b0;

      // ---------------- req held past ack: back-to-back reads ----------------
      tick();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h600; m_rdata = 32'h1111_1111;
      for (int c = 1; c <= 8; c++) begin
         tick();
         check("b2b_rd_en",  32'(m_rd_en), 32'(c == 1 || c == 5));
         check("b2b_p0_ack", 32'(p0_ack),  32'(c == 3 || c == 7));
         if (c >= 3 && c <= 6) check("b2b_rdata_first", p0_rdata, 32'h1111_1111);
         if (c == 3) m_rdata = 32'h2222_2222;
         if (c == 7) begin
            check("b2b_rdata_second", p0_rdata, 32'h2222_2222);
            p0_req = 1'b0;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single cached SDRAM controller port (rd_en/wr_en/addr/data/mask/busy) between the Hazard3 instruction-fetch path (port 0) and load/store path (port 1).
- Converts each requester's level req/ack handshake into the single-cycle enable-pulse protocol the memory controller expects.
- Sequences exactly one outstanding access at a time, watchdogs completion, and returns read data per port.

Parameters:
- ADDR_W, 32, address width on all ports.
- TIMEOUT, 4096, maximum cycles allowed in WAIT before abort; counter width is clog2(TIMEOUT+1).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain; synchronous, active-high.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  1=write, 0=read; stable while p0_req is high.
- p0_addr  in  ADDR_W  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_mask  in  4  port 0 byte mask.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  32  read data; valid while p0_ack is high.
- p1_req, p1_we, p1_addr, p1_wdata, p1_mask, p1_ack, p1_rdata: same as port 0, for port 1.
- m_rd_en  out  1  one-cycle read pulse to the controller.
- m_wr_en  out  1  one-cycle write pulse to the controller.
- m_addr  out  ADDR_W  latched address.
- m_wdata  out  32  latched write data.
- m_mask  out  4  latched mask.
- m_rdata  in  32  controller read data.
- m_busy  in  1  controller busy.
- err  out  1  sticky timeout flag.
- err_port  out  1  port that timed out (last abort).

Behaviour:
- All outputs are registered. While rst is high: state=IDLE, all enables, acks and err low; m_addr, m_wdata, m_mask, rdata and err_port zero; rr_last=1 so port 0 wins first.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If m_busy=0 and any req is high, grant. If only one port requests, grant it. If both request, grant the port != rr_last.
  - Latch we/addr/wdata/mask of the granted port into the m_* registers.
  - Set m_rd_en=~we and m_wr_en=we for the next cycle. Set rr_last=grant. Go to ISSUE.
  - If m_busy=1, stay in IDLE with no grant. This covers a controller still busy after a reset mid-operation.
- ISSUE: the enable is high for exactly this cycle. Clear the enables, clear the timeout counter, go to WAIT.
- WAIT:
  - The first cycle with m_busy=0 is completion; a read hit completes in the first WAIT cycle.
  - On completion: for reads, capture m_rdata into the granted port's rdata; for writes, rdata is unchanged. Set the granted ack for the next cycle and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, load rdata with ERR_DATA, set err=1 and err_port=grant, assert ack, and go to DONE.
- DONE: ack is high for exactly this cycle. Clear it and go to IDLE.
  - The requester must drop req, or present a new request, on the clock edge that ends DONE.
  - A req still high in IDLE is treated as a new access.
- m_addr, m_wdata and m_mask stay stable from ISSUE through DONE.
- Only one access is outstanding at a time. A non-granted req is ignored until IDLE.
- Minimum latency, req high in cycle 0 (IDLE) to ack: IDLE c0, ISSUE c1, WAIT c2 (hit), DONE c3, so ack is high in cycle 3.
- Back-to-back requests from one port have 4-cycle throughput on hits.
- Round-robin guarantees each port waits at most one other access.
- err clears only on rst.

Test Plan:
- Port 0 read, addr 0x100; m_busy stays 0 after ISSUE and m_rdata=0x12345678 -> m_rd_en pulses in cycle 1, p0_ack in cycle 3, p0_rdata=0x12345678, p1_ack stays 0.
- p0_req and p1_req both raised in the same cycle after reset, and held re-asserted for 3 rounds -> grants in order 0,1,0,1,0,1; no more than one m_*_en pulse in any 4-cycle window.
- Port 1 write, addr 0x2000, data 0xCAFEF00D, mask 4'b0011; m_busy high for 10 cycles -> m_wr_en one cycle, m_addr, m_wdata and m_mask stable until p1_ack, p1_ack 1 cycle after m_busy falls.
- m_busy held at 1 after the request, with TIMEOUT=16 -> ack after 16 WAIT cycles with rdata=0xDEADBEEF, err=1, err_port = requesting port; err persists through later good accesses.
- rst asserted during WAIT while m_busy=1, then released with p0_req high -> no enable until m_busy=0, then a normal grant; acks and err are 0 through the reset.
- Requester keeps p0_req high past ack -> the second access starts from IDLE the next cycle; rdata of the first access is held until the second ack.
